instruction_decode_stage: RTL
=============================

# instruction_decode_stage

Single-cycle decode stage of the pipelined MIPS core, sitting directly upstream of `register_file`. It splits the fetched instruction into fields and drives the register file read selectors from them. It merges the register file read data with a write-back bypass and latches operands plus control into the ID/EX pipeline register for the execute stage. It owns the fetch→decode and decode→execute valid/ready handshakes, load-use stall detection and flush.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; instruction, PC and operand width.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_valid`  in  1  fetch presents an instruction.
- `if_ready`  out  1  decode accepts this cycle (combinational).
- `if_instruction`  in  32  instruction word.
- `if_pc`  in  32  PC of that instruction.
- `flush`  in  1  discard the instruction in decode and the ID/EX contents.
- `selector_out1`  out  5  register file read port 1 = instr[25:21] (rs), combinational.
- `selector_out2`  out  5  register file read port 2 = instr[20:16] (rt), combinational.
- `value_out1`, `value_out2`  in  32  register file read data.
- `wb_write_enable`  in  1  write-back is writing the register file this cycle.
- `wb_selector`  in  5  write-back destination.
- `wb_value`  in  32  write-back data.
- `ex_valid`  out  1  ID/EX holds a valid instruction.
- `ex_ready`  in  1  execute consumes ID/EX this cycle.
- `ex_pc`, `ex_rs_value`, `ex_rt_value`, `ex_imm`  out  32  latched PC, operands, extended immediate.
- `ex_dest`  out  5  destination register.
- `ex_alu_op`  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 LUI.
- `ex_alu_src_imm`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_illegal`  out  1  control flags.
- `ex_branch`  out  2  00 none, 01 BEQ, 10 BNE.
- `ex_shamt`  out  5  instr[10:6].

## Operation
- Decoded set:
  - R-type, opcode 0, by funct: add 0x20 / addu 0x21 → ADD; sub 0x22 / subu 0x23 → SUB; and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sll 0x00, srl 0x02. Destination is rd; `ex_reg_write`=1.
  - I-type, by opcode: addi 0x08 / addiu 0x09 → ADD with sign-extended imm; slti 0x0A → SLT with sign-extended imm; andi 0x0C, ori 0x0D, xori 0x0E → zero-extended imm; lui 0x0F → LUI with imm in [31:16]; lw 0x23 → ADD, `ex_mem_read`; sw 0x2B → ADD, `ex_mem_write`, no `ex_reg_write`; beq 0x04 / bne 0x05 → SUB, `ex_branch`, sign-extended imm, no `ex_reg_write`. Destination is rt.
- Any other encoding sets `ex_illegal`=1 and clears all write, memory and branch flags.
- `ex_reg_write` is forced to 0 whenever `ex_dest`=0.
- Bypass: if `wb_write_enable` && `wb_selector`≠0 && `wb_selector`==rs, latch `wb_value` as `ex_rs_value`; otherwise latch `value_out1`. The same rule applies to rt with `value_out2`. Register 0 is never bypassed.
- Load-use stall: `ex_valid` && `ex_mem_read` && `ex_dest`≠0 && (`ex_dest`==rs, or `ex_dest`==rt and the instruction uses rt: R-type, sw, beq, bne). On a stall, `if_ready`=0; if `ex_ready`=1, ID/EX loads a bubble (`ex_valid`←0).
- `if_ready` = !`reset` && !stall && (!`ex_valid` || `ex_ready`).

## Timing
- Latency 1 cycle: an instruction accepted at edge N (`if_valid` && `if_ready`) is on the `ex_*` outputs from N+1.
- ID/EX loads the new instruction on accept and clears `ex_valid` when `ex_ready`=1 with nothing accepted. It holds all contents while `ex_valid`=1 and `ex_ready`=0.
- `flush` at edge N sets `ex_valid`←0 and overrides accept and stall. `if_ready` is unaffected by `flush`.
- `reset` at an edge clears all `ex_*` outputs to 0. `if_ready` is 0 while `reset` is high.
- Selectors and bypass are combinational, so a same-cycle write-back is forwarded. There is no extra bubble for write-back.

## Test plan
- Reset, then accept `addi $1,$0,5` (0x20010005) → next cycle `ex_valid`=1, `ex_alu_op`=0, `ex_imm`=5, `ex_dest`=1, `ex_reg_write`=1.
- Accept `add $3,$1,$2` while wb writes $1=10, with register file $2=20 → `selector_out1`=1, `selector_out2`=2, `ex_rs_value`=10, `ex_rt_value`=20, `ex_dest`=3.
- `lw $4,0($1)` followed by `sub $5,$4,$4` → one bubble cycle (`if_ready`=0, `ex_valid`=0), then sub is accepted.
- Hold `ex_ready`=0 for 3 cycles with `ex_valid`=1 → `ex_*` stable and `if_ready`=0; `ex_ready`=1 → the next instruction is latched.
- `andi $1,$1,0xFFFF` → `ex_imm`=0x0000FFFF; `beq` with imm 0xFFFF → `ex_imm`=0xFFFFFFFF, `ex_branch`=01, `ex_reg_write`=0.
- Opcode 0x3F → `ex_illegal`=1, all write, memory and branch flags 0; `flush` on the same edge → `ex_valid`=0.

Source files
------------

// File: rtl/instruction_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode_stage
// Description : MIPS decode stage. Splits the instruction into fields, adds
//               write-back bypass, detects load-use hazards and loads the
//               ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instruction,
    input  logic [WIDTH-1:0] if_pc,
    input  logic             flush,
    output logic [4:0]       selector_out1,
    output logic [4:0]       selector_out2,
    input  logic [WIDTH-1:0] value_out1,
    input  logic [WIDTH-1:0] value_out2,
    input  logic             wb_write_enable,
    input  logic [4:0]       wb_selector,
    input  logic [WIDTH-1:0] wb_value,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] ex_rs_value,
    output logic [WIDTH-1:0] ex_rt_value,
    output logic [WIDTH-1:0] ex_imm,
    output logic [4:0]       ex_dest,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alu_src_imm,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_illegal,
    output logic [1:0]       ex_branch,
    output logic [4:0]       ex_shamt
);

    localparam logic [3:0] c_ALU_ADD = 4'd0;
    localparam logic [3:0] c_ALU_SUB = 4'd1;
    localparam logic [3:0] c_ALU_AND = 4'd2;
    localparam logic [3:0] c_ALU_OR  = 4'd3;
    localparam logic [3:0] c_ALU_XOR = 4'd4;
    localparam logic [3:0] c_ALU_NOR = 4'd5;
    localparam logic [3:0] c_ALU_SLT = 4'd6;
    localparam logic [3:0] c_ALU_SLL = 4'd7;
    localparam logic [3:0] c_ALU_SRL = 4'd8;
    localparam logic [3:0] c_ALU_LUI = 4'd9;

    logic [5:0] w_opcode;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [5:0] w_funct;

    assign w_opcode = if_instruction[31:26];
    assign w_rs     = if_instruction[25:21];
    assign w_rt     = if_instruction[20:16];
    assign w_rd     = if_instruction[15:11];
    assign w_funct  = if_instruction[5:0];

    assign selector_out1 = w_rs;
    assign selector_out2 = w_rt;

    logic [WIDTH-1:0] w_imm_sext;
    logic [WIDTH-1:0] w_imm_zext;
    logic [WIDTH-1:0] w_imm_lui;

    assign w_imm_sext = {{(WIDTH-16){if_instruction[15]}}, if_instruction[15:0]};
    assign w_imm_zext = {{(WIDTH-16){1'b0}}, if_instruction[15:0]};
    assign w_imm_lui  = {if_instruction[15:0], {(WIDTH-16){1'b0}}};

    logic [3:0]       w_alu_op;
    logic             w_alu_src_imm;
    logic             w_reg_write;
    logic             w_mem_read;
    logic             w_mem_write;
    logic [1:0]       w_branch;
    logic             w_illegal;
    logic             w_uses_rt;
    logic [4:0]       w_dest;
    logic [WIDTH-1:0] w_imm;

    // R-type instructions carry the sign-extended low half as ex_imm; it is unused downstream.
    always_comb begin
        w_alu_op      = c_ALU_ADD;
        w_alu_src_imm = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_branch      = 2'b00;
        w_illegal     = 1'b0;
        w_uses_rt     = 1'b0;
        w_dest        = w_rt;
        w_imm         = w_imm_sext;
        case (w_opcode)
            6'h00: begin
                w_dest      = w_rd;
                w_reg_write = 1'b1;
                w_uses_rt   = 1'b1;
                case (w_funct)
                    6'h20, 6'h21: w_alu_op = c_ALU_ADD;
                    6'h22, 6'h23: w_alu_op = c_ALU_SUB;
                    6'h24:        w_alu_op = c_ALU_AND;
                    6'h25:        w_alu_op = c_ALU_OR;
                    6'h26:        w_alu_op = c_ALU_XOR;
                    6'h27:        w_alu_op = c_ALU_NOR;
                    6'h2A:        w_alu_op = c_ALU_SLT;
                    6'h00:        w_alu_op = c_ALU_SLL;
                    6'h02:        w_alu_op = c_ALU_SRL;
                    default:      w_illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin
                w_alu_src_imm = 1'b1;
                w_reg_write   = 1'b1;
            end
            6'h0A: begin
                w_alu_op      = c_ALU_SLT;
                w_alu_src_imm = 1'b1;
                w_reg_write   = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                w_alu_op      = (w_opcode == 6'h0C) ? c_ALU_AND :
                                (w_opcode == 6'h0D) ? c_ALU_OR  : c_ALU_XOR;
                w_imm         = w_imm_zext;
                w_alu_src_imm = 1'b1;
                w_reg_write   = 1'b1;
            end
            6'h0F: begin
                w_alu_op      = c_ALU_LUI;
                w_imm         = w_imm_lui;
                w_alu_src_imm = 1'b1;
                w_reg_write   = 1'b1;
            end
            6'h23: begin
                w_alu_src_imm = 1'b1;
                w_reg_write   = 1'b1;
                w_mem_read    = 1'b1;
            end
            6'h2B: begin
                w_alu_src_imm = 1'b1;
                w_mem_write   = 1'b1;
                w_uses_rt     = 1'b1;
            end
            6'h04, 6'h05: begin
                w_alu_op  = c_ALU_SUB;
                w_branch  = (w_opcode == 6'h04) ? 2'b01 : 2'b10;
                w_uses_rt = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_alu_op      = c_ALU_ADD;
            w_alu_src_imm = 1'b0;
            w_reg_write   = 1'b0;
            w_mem_read    = 1'b0;
            w_mem_write   = 1'b0;
            w_branch      = 2'b00;
            w_dest        = 5'd0;
        end
        if (w_dest == 5'd0) begin
            w_reg_write = 1'b0;
        end
    end

    // Register 0 is hardwired, so a write-back to it is never forwarded.
    logic [WIDTH-1:0] w_rs_value;
    logic [WIDTH-1:0] w_rt_value;

    assign w_rs_value = (wb_write_enable && wb_selector != 5'd0 && wb_selector == w_rs) ? wb_value : value_out1;
    assign w_rt_value = (wb_write_enable && wb_selector != 5'd0 && wb_selector == w_rt) ? wb_value : value_out2;

    logic             r_ex_valid;
    logic [WIDTH-1:0] r_ex_pc;
    logic [WIDTH-1:0] r_ex_rs_value;
    logic [WIDTH-1:0] r_ex_rt_value;
    logic [WIDTH-1:0] r_ex_imm;
    logic [4:0]       r_ex_dest;
    logic [3:0]       r_ex_alu_op;
    logic             r_ex_alu_src_imm;
    logic             r_ex_reg_write;
    logic             r_ex_mem_read;
    logic             r_ex_mem_write;
    logic             r_ex_illegal;
    logic [1:0]       r_ex_branch;
    logic [4:0]       r_ex_shamt;

    logic w_stall;
    logic w_accept;

    assign w_stall  = r_ex_valid && r_ex_mem_read && (r_ex_dest != 5'd0) &&
                      ((r_ex_dest == w_rs) || ((r_ex_dest == w_rt) && w_uses_rt));
    assign if_ready = !reset && !w_stall && (!r_ex_valid || ex_ready);
    assign w_accept = if_valid && if_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ex_valid       <= 1'b0;
            r_ex_pc          <= '0;
            r_ex_rs_value    <= '0;
            r_ex_rt_value    <= '0;
            r_ex_imm         <= '0;
            r_ex_dest        <= '0;
            r_ex_alu_op      <= '0;
            r_ex_alu_src_imm <= 1'b0;
            r_ex_reg_write   <= 1'b0;
            r_ex_mem_read    <= 1'b0;
            r_ex_mem_write   <= 1'b0;
            r_ex_illegal     <= 1'b0;
            r_ex_branch      <= '0;
            r_ex_shamt       <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid       <= 1'b1;
            r_ex_pc          <= if_pc;
            r_ex_rs_value    <= w_rs_value;
            r_ex_rt_value    <= w_rt_value;
            r_ex_imm         <= w_imm;
            r_ex_dest        <= w_dest;
            r_ex_alu_op      <= w_alu_op;
            r_ex_alu_src_imm <= w_alu_src_imm;
            r_ex_reg_write   <= w_reg_write;
            r_ex_mem_read    <= w_mem_read;
            r_ex_mem_write   <= w_mem_write;
            r_ex_illegal     <= w_illegal;
            r_ex_branch      <= w_branch;
            r_ex_shamt       <= if_instruction[10:6];
        end else if (ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid       = r_ex_valid;
    assign ex_pc          = r_ex_pc;
    assign ex_rs_value    = r_ex_rs_value;
    assign ex_rt_value    = r_ex_rt_value;
    assign ex_imm         = r_ex_imm;
    assign ex_dest        = r_ex_dest;
    assign ex_alu_op      = r_ex_alu_op;
    assign ex_alu_src_imm = r_ex_alu_src_imm;
    assign ex_reg_write   = r_ex_reg_write;
    assign ex_mem_read    = r_ex_mem_read;
    assign ex_mem_write   = r_ex_mem_write;
    assign ex_illegal     = r_ex_illegal;
    assign ex_branch      = r_ex_branch;
    assign ex_shamt       = r_ex_shamt;

endmodule
`default_nettype wire
